// File: rtl/sw_led_pkg.sv
// sw_led_pkg: shared types and defaults for the switch/LED controller.
//   state_t              FSM encoding for sw_led_ctrl
//   DEBOUNCE_CYC_DEF     10 ms debounce window at 50 MHz
//   HALF_PERIOD_CYC_DEF  0.5 s green-LED half-period at 50 MHz
//   cnt_width()          counter width for a modulus, never below 1 bit
package sw_led_pkg;

  typedef enum logic [0:0] {
    ST_OFF   = 1'b0,
    ST_BLINK = 1'b1
  } state_t;

  localparam int DEBOUNCE_CYC_DEF    = 500_000;
  localparam int HALF_PERIOD_CYC_DEF = 25_000_000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_led_ctrl_if.sv
// sw_led_ctrl_if: board-side switch/LED bundle.
//   SW         raw switch level (board -> controller)
//   LED_ROUGE  red LED, 1 = on
//   LED_VERTE  green LED, 1 = on
//   PRESS_CNT  debounced press count, only with SW_LED_CTRL_PRESS_CNT_EN
// master = board / stimulus side, slave = sw_led_ctrl.
interface sw_led_ctrl_if;
  logic       SW;
  logic       LED_ROUGE;
  logic       LED_VERTE;
`ifdef SW_LED_CTRL_PRESS_CNT_EN
  logic [7:0] PRESS_CNT;

  modport master (output SW, input LED_ROUGE, input LED_VERTE, input PRESS_CNT);
  modport slave  (input SW, output LED_ROUGE, output LED_VERTE, output PRESS_CNT);
`else
  modport master (output SW, input LED_ROUGE, input LED_VERTE);
  modport slave  (input SW, output LED_ROUGE, output LED_VERTE);
`endif
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchroniser, stability counter and rising-edge pulse.
//   CLK      in   system clock
//   NRST     in   asynchronous active-low reset
//   i_sw     in   raw switch level, asynchronous to CLK
//   o_sw_db  out  debounced level
//   o_press  out  one-cycle pulse on each debounced rising edge
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic CLK,
  input  logic NRST,
  input  logic i_sw,
  output logic o_sw_db,
  output logic o_press
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          r_sw_s1;
  logic          r_sw_s2;
  logic          r_sw_db;
  logic          r_sw_db_d;
  logic [DW-1:0] r_deb_cnt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_sw_s1   <= 1'b0;
      r_sw_s2   <= 1'b0;
      r_sw_db   <= 1'b0;
      r_sw_db_d <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sw_s1   <= i_sw;
      r_sw_s2   <= r_sw_s1;
      r_sw_db_d <= r_sw_db;
      // Any return to the accepted level restarts the stability window.
      if (r_sw_s2 == r_sw_db) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_sw_db   <= r_sw_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign o_sw_db = r_sw_db;
  // sw_db_d resets low, so a switch held through reset still yields one press.
  assign o_press = r_sw_db & ~r_sw_db_d;

endmodule

// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: debounced switch toggles between LEDs-off (red on) and
// green-blink mode. All outputs are registered.
//   CLK   in   system clock (50 MHz)
//   NRST  in   asynchronous active-low reset
//   bus   sw_led_ctrl_if.slave: SW in, LED_ROUGE / LED_VERTE out,
//         PRESS_CNT out when SW_LED_CTRL_PRESS_CNT_EN is defined
// Optional feature macro: SW_LED_CTRL_PRESS_CNT_EN (8-bit wrapping press counter).
//
// state    | meaning
// ST_OFF   | red on, green off, blink divider held at 0
// ST_BLINK | red off, green toggles every HALF_PERIOD_CYC cycles
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC    = DEBOUNCE_CYC_DEF,
  parameter int HALF_PERIOD_CYC = HALF_PERIOD_CYC_DEF
) (
  input  logic         CLK,
  input  logic         NRST,
  sw_led_ctrl_if.slave bus
);

  localparam int BW = cnt_width(HALF_PERIOD_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_PERIOD_CYC - 1);

  logic          w_sw_db;
  logic          w_press_raw;
  logic          w_press;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_led_rouge;
  logic          r_led_verte;
  logic [BW-1:0] r_blink_cnt;
  logic          w_led_rouge_nxt;
  logic          w_led_verte_nxt;
  logic [BW-1:0] w_blink_cnt_nxt;

  sw_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .CLK     (CLK),
    .NRST    (NRST),
    .i_sw    (bus.SW),
    .o_sw_db (w_sw_db),
    .o_press (w_press_raw)
  );

  // A press is by construction coincident with a high debounced level.
  assign w_press = w_press_raw & w_sw_db;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state     <= ST_OFF;
      r_led_rouge <= 1'b1;
      r_led_verte <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_led_rouge <= w_led_rouge_nxt;
      r_led_verte <= w_led_verte_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_led_rouge_nxt = r_led_rouge;
    w_led_verte_nxt = r_led_verte;
    w_blink_cnt_nxt = r_blink_cnt;
    unique case (r_state)
      ST_OFF: begin
        w_led_rouge_nxt = 1'b1;
        w_led_verte_nxt = 1'b0;
        w_blink_cnt_nxt = '0;
        if (w_press) begin
          w_state_nxt     = ST_BLINK;
          w_led_rouge_nxt = 1'b0;
          w_led_verte_nxt = 1'b1;
        end
      end
      ST_BLINK: begin
        w_led_rouge_nxt = 1'b0;
        // Press has priority over the half-period wrap; the toggle is dropped.
        if (w_press) begin
          w_state_nxt     = ST_OFF;
          w_led_rouge_nxt = 1'b1;
          w_led_verte_nxt = 1'b0;
          w_blink_cnt_nxt = '0;
        end else if (r_blink_cnt == BLINK_LAST) begin
          w_blink_cnt_nxt = '0;
          w_led_verte_nxt = ~r_led_verte;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  assign bus.LED_ROUGE = r_led_rouge;
  assign bus.LED_VERTE = r_led_verte;

`ifdef SW_LED_CTRL_PRESS_CNT_EN
  logic [7:0] r_press_cnt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_press_cnt <= 8'd0;
    end else if (w_press) begin
      r_press_cnt <= r_press_cnt + 8'd1;
    end
  end

  assign bus.PRESS_CNT = r_press_cnt;
`endif

endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb_sw_led_ctrl: directed and random checks of sw_led_ctrl with
// DEBOUNCE_CYC=4, HALF_PERIOD_CYC=8 and a 20 ns clock.
// Honours SW_LED_CTRL_PRESS_CNT_EN when defined.
module tb_sw_led_ctrl;

  localparam int DEB = 4;
  localparam int HP  = 8;

  logic CLK;
  logic NRST;

  sw_led_ctrl_if u_if ();

  sw_led_ctrl #(
    .DEBOUNCE_CYC    (DEB),
    .HALF_PERIOD_CYC (HP)
  ) u_dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (u_if)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_leds(input string name, input logic exp_r, input logic exp_v);
    check({name, "_rouge"}, {7'd0, u_if.LED_ROUGE}, {7'd0, exp_r});
    check({name, "_verte"}, {7'd0, u_if.LED_VERTE}, {7'd0, exp_v});
  endtask

  // Behavioural reference for the random phase, advanced once per rising edge.
  logic     m_s1, m_s2, m_db, m_db_d, m_blink;
  int       m_cnt;
  logic [7:0] m_press_cnt;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_db_d = 0; m_blink = 0;
    m_cnt = 0; m_press_cnt = 8'd0;
  endtask

  task automatic model_step(input logic s);
    logic press;
    logic db_old;
    press  = m_db & ~m_db_d;
    db_old = m_db;
    if (m_s2 == m_db) m_cnt = 0;
    else if (m_cnt == DEB - 1) begin
      m_db  = m_s2;
      m_cnt = 0;
    end else m_cnt++;
    m_db_d = db_old;
    m_s2   = m_s1;
    m_s1   = s;
    if (press) begin
      m_blink     = ~m_blink;
      m_press_cnt = m_press_cnt + 8'd1;
    end
  endtask

  typedef struct {
    logic sw;
    int   cyc;
    logic exp_r;
    logic exp_v;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Each entry: drive sw at a falling edge, wait cyc falling edges, compare.
    // First entry's drive precedes edge k: press lands at k+5, LEDs at k+6.
    vecs[0]  = '{1'b1, 6,  1'b1, 1'b0};  // after k+5: still off
    vecs[1]  = '{1'b1, 1,  1'b0, 1'b1};  // after k+6: blink, green on
    vecs[2]  = '{1'b1, 7,  1'b0, 1'b1};  // after k+13: last cycle of first half
    vecs[3]  = '{1'b1, 1,  1'b0, 1'b0};  // after k+14: toggled
    vecs[4]  = '{1'b1, 7,  1'b0, 1'b0};  // after k+21
    vecs[5]  = '{1'b1, 1,  1'b0, 1'b1};  // after k+22: toggled back
    vecs[6]  = '{1'b0, 7,  1'b0, 1'b1};  // release: falling edge ignored
    vecs[7]  = '{1'b0, 1,  1'b0, 1'b0};  // after k+30: toggle
    vecs[8]  = '{1'b1, 6,  1'b0, 1'b0};  // second rise, press not yet applied
    vecs[9]  = '{1'b1, 1,  1'b1, 1'b0};  // back to off 6 cycles after rise
    vecs[10] = '{1'b1, 10, 1'b1, 1'b0};  // held high: stays off
    vecs[11] = '{1'b0, 10, 1'b1, 1'b0};  // release: stays off

    NRST     = 1'b0;
    u_if.SW  = 1'b0;

    // Reset state held for three cycles
    repeat (3) begin
      @(negedge CLK);
      check_leds("reset", 1'b1, 1'b0);
`ifdef SW_LED_CTRL_PRESS_CNT_EN
      check("reset_cnt", u_if.PRESS_CNT, 8'd0);
`endif
    end
    NRST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check_leds("post_reset", 1'b1, 1'b0);
    end

    // Table-driven press / blink / return sequence
    for (int i = 0; i < 12; i++) begin
      u_if.SW = vecs[i].sw;
      repeat (vecs[i].cyc) @(negedge CLK);
      check_leds($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_v);
    end
`ifdef SW_LED_CTRL_PRESS_CNT_EN
    check("vec_cnt", u_if.PRESS_CNT, 8'd2);
`endif

    // Short glitches (3 cycles high) never produce a press
    for (int g = 0; g < 10; g++) begin
      u_if.SW = 1'b1;
      repeat (3) @(negedge CLK);
      u_if.SW = 1'b0;
      repeat (5) @(negedge CLK);
      check_leds($sformatf("glitch%0d", g), 1'b1, 1'b0);
    end

    // Press coinciding with the half-period wrap: press wins, goes to off
    u_if.SW = 1'b1;               // before edge k1; blink entered at k1+6
    repeat (4) @(negedge CLK);
    u_if.SW = 1'b0;               // before edge k1+4
    repeat (4) @(negedge CLK);
    check_leds("wrap_inblink", 1'b0, 1'b1);   // after k1+7
    u_if.SW = 1'b1;               // before edge k1+8; press applied at k1+14
    repeat (6) @(negedge CLK);
    check_leds("wrap_before", 1'b0, 1'b1);    // after k1+13, divider at last count
    @(negedge CLK);
    check_leds("wrap_press", 1'b1, 1'b0);     // after k1+14
    repeat (10) @(negedge CLK);
    check_leds("wrap_stay", 1'b1, 1'b0);
`ifdef SW_LED_CTRL_PRESS_CNT_EN
    check("wrap_cnt", u_if.PRESS_CNT, 8'd4);
`endif

    // Async reset mid-blink with SW held high
    u_if.SW = 1'b0;
    repeat (8) @(negedge CLK);
    u_if.SW = 1'b1;
    repeat (7) @(negedge CLK);
    check_leds("rst5_blink", 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    NRST = 1'b0;
    #1;
    check_leds("rst5_async", 1'b1, 1'b0);
`ifdef SW_LED_CTRL_PRESS_CNT_EN
    check("rst5_cnt", u_if.PRESS_CNT, 8'd0);
`endif
    repeat (3) @(negedge CLK);
    NRST = 1'b1;                  // SW still high: acts as a rise before edge k
    repeat (6) @(negedge CLK);
    check_leds("rst5_wait", 1'b1, 1'b0);
    @(negedge CLK);
    check_leds("rst5_press", 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    check("rst5_rouge_hold", {7'd0, u_if.LED_ROUGE}, 8'd0);

    // Random switch activity against the reference model
    u_if.SW = 1'b0;
    NRST    = 1'b0;
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    model_reset();
    begin
      int hold;
      hold = 0;
      for (int c = 0; c < 1000; c++) begin
        if (hold == 0) begin
          u_if.SW = 1'($urandom_range(0, 1));
          hold    = $urandom_range(1, 12);
        end
        hold--;
        @(posedge CLK);
        model_step(u_if.SW);
        @(negedge CLK);
        check("rand_rouge", {7'd0, u_if.LED_ROUGE}, {7'd0, ~m_blink});
        if (!m_blink) check("rand_verte_off", {7'd0, u_if.LED_VERTE}, 8'd0);
`ifdef SW_LED_CTRL_PRESS_CNT_EN
        check("rand_cnt", u_if.PRESS_CNT, m_press_cnt);
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
